// File: rtl/keypad_emulator.sv
//==============================================================================
// keypad_emulator
//------------------------------------------------------------------------------
// Switch-side model of a 4x4 matrix keypad. It presses a latched sequence of
// key codes one at a time. While a key is held, that key's row line is
// asserted whenever the scanner drives the key's column.
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module keypad_emulator #(
  parameter int NUM_KEYS       = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       start_i,
  input  logic [4*NUM_KEYS-1:0]                      code_i,
  input  logic [3:0]                                 col_i,
  output logic [3:0]                                 row_o,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       err_o,
  output logic [((NUM_KEYS>1)?$clog2(NUM_KEYS):1)-1:0] key_idx_o
);

  // Counter and index widths. Each counter only has to reach its terminal
  // value minus one before it is cleared, so none of them can wrap.
  localparam int IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int PCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_KEYS - 1);
  localparam logic [PCNT_W-1:0] PRESS_LAST = PCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST  = HCNT_W'(HOLD_CYCLES - 1);
  // A zero-length gap still spends one transit cycle in GAP.
  localparam logic [GCNT_W-1:0] GAP_LAST   = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]            state_q,     state_d;
  logic [4*NUM_KEYS-1:0] code_q,      code_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic [PCNT_W-1:0]     press_cnt_q, press_cnt_d;
  logic [HCNT_W-1:0]     hold_cnt_q,  hold_cnt_d;
  logic [GCNT_W-1:0]     gap_cnt_q,   gap_cnt_d;
  logic                  done_q,      done_d;
  logic                  err_q,       err_d;

  logic [3:0] key_code;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       match;

  // Select the nibble of the latched sequence for the key being pressed.
  always_comb begin
    key_code = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        key_code = code_q[i*4 +: 4];
      end
    end
  end

  // Physical keypad layout: key code to (row line, column line).
  always_comb begin
    key_row = 4'b0000;
    key_col = 4'b0000;
    case (key_code)
      4'd1:  begin key_row = 4'b1000; key_col = 4'b1000; end
      4'd2:  begin key_row = 4'b1000; key_col = 4'b0100; end
      4'd3:  begin key_row = 4'b1000; key_col = 4'b0010; end
      4'd10: begin key_row = 4'b1000; key_col = 4'b0001; end
      4'd4:  begin key_row = 4'b0100; key_col = 4'b1000; end
      4'd5:  begin key_row = 4'b0100; key_col = 4'b0100; end
      4'd6:  begin key_row = 4'b0100; key_col = 4'b0010; end
      4'd11: begin key_row = 4'b0100; key_col = 4'b0001; end
      4'd7:  begin key_row = 4'b0010; key_col = 4'b1000; end
      4'd8:  begin key_row = 4'b0010; key_col = 4'b0100; end
      4'd9:  begin key_row = 4'b0010; key_col = 4'b0010; end
      4'd12: begin key_row = 4'b0010; key_col = 4'b0001; end
      4'd14: begin key_row = 4'b0001; key_col = 4'b1000; end
      4'd0:  begin key_row = 4'b0001; key_col = 4'b0100; end
      4'd15: begin key_row = 4'b0001; key_col = 4'b0010; end
      4'd13: begin key_row = 4'b0001; key_col = 4'b0001; end
      default: begin key_row = 4'b0000; key_col = 4'b0000; end
    endcase
  end

  // A key is seen whenever its column bit is driven, even if col is not one-hot.
  assign match = |(col_i & key_col);

  // Row sense follows col with no latency, like a real closed switch.
  assign row_o = ((state_q == PRESS) && match) ? key_row : 4'b0000;

  // Sequence control: press each key until enough matched cycles, then gap.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    idx_d       = idx_q;
    press_cnt_d = press_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          code_d      = code_i;
          idx_d       = '0;
          press_cnt_d = '0;
          hold_cnt_d  = '0;
          gap_cnt_d   = '0;
          err_d       = 1'b0;
          state_d     = PRESS;
        end
      end
      PRESS: begin
        press_cnt_d = press_cnt_q + 1'b1;
        if (match) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        // Completion takes priority over a simultaneous timeout.
        if (match && (hold_cnt_q == HOLD_LAST)) begin
          press_cnt_d = '0;
          hold_cnt_d  = '0;
          gap_cnt_d   = '0;
          state_d     = GAP;
        end else if (press_cnt_q == PRESS_LAST) begin
          press_cnt_d = '0;
          hold_cnt_d  = '0;
          err_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = PRESS;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops the machine to IDLE, releasing row at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      code_q      <= '0;
      idx_q       <= '0;
      press_cnt_q <= '0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      idx_q       <= idx_d;
      press_cnt_q <= press_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign key_idx_o = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
//==============================================================================
// tb_keypad_emulator
//------------------------------------------------------------------------------
// Self-checking bench for keypad_emulator: key-map table, directed sequences,
// randomized scans against a sequence-level reference model, and a second
// instance with a longer gap.
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_keypad_emulator;

  localparam int NK   = 4;
  localparam int HOLD = 2;
  localparam int GAPC = 1;
  localparam int TMO  = 64;
  localparam int MAXC = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] code;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        busy, done, err;
  logic [1:0]  kidx;

  logic        start2;
  logic [7:0]  code2;
  logic [3:0]  col2;
  logic [3:0]  row2;
  logic        busy2, done2, err2;
  logic [0:0]  kidx2;

  always #5 clk = ~clk;

  keypad_emulator #(.NUM_KEYS(NK), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .code_i(code), .col_i(col),
    .row_o(row), .busy_o(busy), .done_o(done), .err_o(err), .key_idx_o(kidx));

  keypad_emulator #(.NUM_KEYS(2), .HOLD_CYCLES(2), .GAP_CYCLES(3), .TIMEOUT_CYCLES(64)) u_dut_gap (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .code_i(code2), .col_i(col2),
    .row_o(row2), .busy_o(busy2), .done_o(done2), .err_o(err2), .key_idx_o(kidx2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keypad layout as printed on the device: [row top..bottom][col left..right].
  int layout [4][4];

  task automatic key_geom(input logic [3:0] c, output logic [3:0] kr, output logic [3:0] kc);
    kr = 4'b0000;
    kc = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (layout[r][k] == int'(c)) begin
          kr = 4'b1000 >> r;
          kc = 4'b1000 >> k;
        end
  endtask

  // Per-cycle scan stimulus and expected outputs, cycle 0 = first press cycle.
  logic [3:0] cols   [MAXC];
  logic [3:0] e_row  [MAXC];
  bit         e_busy [MAXC];
  bit         e_done [MAXC];
  bit         e_err  [MAXC];
  bit         e_idxv [MAXC];
  int         e_idx  [MAXC];

  // Reference model: walk the scan trace key by key, counting matched cycles.
  task automatic build_expect(input logic [15:0] c, output int len);
    int t;
    bit aborted;
    t = 0;
    aborted = 0;
    for (int k = 0; k < NK && !aborted; k++) begin
      logic [3:0] kr, kc;
      int matched, pt;
      key_geom(c[k*4 +: 4], kr, kc);
      matched = 0;
      pt = 0;
      while (matched < HOLD && !aborted) begin
        bit m;
        m = ((cols[t] & kc) != 4'b0000);
        e_row[t] = m ? kr : 4'b0000;
        e_busy[t] = 1; e_done[t] = 0; e_err[t] = 0; e_idxv[t] = 1; e_idx[t] = k;
        if (m) matched++;
        pt++;
        t++;
        if (matched < HOLD && pt == TMO) aborted = 1;
      end
      if (!aborted) begin
        for (int g = 0; g < ((GAPC > 0) ? GAPC : 1); g++) begin
          e_row[t] = 4'b0000;
          e_busy[t] = 1; e_done[t] = 0; e_err[t] = 0; e_idxv[t] = 1; e_idx[t] = k;
          t++;
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      e_row[t] = 4'b0000;
      e_busy[t] = 0; e_done[t] = (!aborted && j == 0); e_err[t] = aborted;
      e_idxv[t] = 0; e_idx[t] = 0;
      t++;
    end
    len = t;
  endtask

  // mode 0: rotating scan, 1: no column driven, 2: random, 3: sparse random.
  task automatic run_seq(input logic [15:0] c, input int mode, input int mid_start);
    int len;
    for (int t = 0; t < MAXC; t++) begin
      case (mode)
        0: cols[t] = 4'b1000 >> (t % 4);
        1: cols[t] = 4'b0000;
        2: cols[t] = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 0))
                                                 : (4'b1000 >> $urandom_range(3, 0));
        default: cols[t] = ($urandom_range(39, 0) == 0) ? (4'b1000 >> $urandom_range(3, 0)) : 4'b0000;
      endcase
    end
    build_expect(c, len);
    @(negedge clk);
    start = 1'b1;
    code  = c;
    col   = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < len; t++) begin
      col = cols[t];
      if (t == mid_start) begin
        start = 1'b1;
        code  = ~c;
      end else begin
        start = 1'b0;
      end
      #1;
      chk("row",  32'(row),  32'(e_row[t]));
      chk("busy", 32'(busy), 32'(e_busy[t]));
      chk("done", 32'(done), 32'(e_done[t]));
      chk("err",  32'(err),  32'(e_err[t]));
      if (e_idxv[t]) chk("key_idx", 32'(kidx), 32'(e_idx[t]));
      @(negedge clk);
    end
    start = 1'b0;
    col   = 4'b0000;
  endtask

  typedef struct {
    logic [3:0] code;
    logic [3:0] col;
    logic [3:0] row;
  } map_vec_t;

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic       done;
    logic       idx;
  } gap_vec_t;

  map_vec_t mv [20];
  gap_vec_t gv [14];

  initial begin
    rst_n = 1'b0; start = 1'b0; code = '0; col = '0;
    start2 = 1'b0; code2 = '0; col2 = '0;

    layout = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    mv[0]  = '{4'd1,  4'b1000, 4'b1000}; mv[1]  = '{4'd2,  4'b0100, 4'b1000};
    mv[2]  = '{4'd3,  4'b0010, 4'b1000}; mv[3]  = '{4'd10, 4'b0001, 4'b1000};
    mv[4]  = '{4'd4,  4'b1000, 4'b0100}; mv[5]  = '{4'd5,  4'b0100, 4'b0100};
    mv[6]  = '{4'd6,  4'b0010, 4'b0100}; mv[7]  = '{4'd11, 4'b0001, 4'b0100};
    mv[8]  = '{4'd7,  4'b1000, 4'b0010}; mv[9]  = '{4'd8,  4'b0100, 4'b0010};
    mv[10] = '{4'd9,  4'b0010, 4'b0010}; mv[11] = '{4'd12, 4'b0001, 4'b0010};
    mv[12] = '{4'd14, 4'b1000, 4'b0001}; mv[13] = '{4'd0,  4'b0100, 4'b0001};
    mv[14] = '{4'd15, 4'b0010, 4'b0001}; mv[15] = '{4'd13, 4'b0001, 4'b0001};
    mv[16] = '{4'd5,  4'b1011, 4'b0000}; mv[17] = '{4'd5,  4'b1111, 4'b0100};
    mv[18] = '{4'd13, 4'b0011, 4'b0001}; mv[19] = '{4'd1,  4'b0111, 4'b0000};

    // Sequence * then # with a three-cycle gap.
    gv[0]  = '{4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0};
    gv[1]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0};
    gv[2]  = '{4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0};
    gv[3]  = '{4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0};
    gv[4]  = '{4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0};
    gv[5]  = '{4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0};
    gv[6]  = '{4'b0010, 4'b0001, 1'b1, 1'b0, 1'b1};
    gv[7]  = '{4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1};
    gv[8]  = '{4'b0010, 4'b0001, 1'b1, 1'b0, 1'b1};
    gv[9]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1};
    gv[10] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1};
    gv[11] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1};
    gv[12] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1};
    gv[13] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};

    // Reset values, during and just after reset.
    repeat (2) @(negedge clk);
    chk("rst_row",  32'(row),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err",  32'(err),  32'h0);
    chk("rst_idx",  32'(kidx), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_row",  32'(row),  32'h0);

    // Key map table; each press is cut short by an asynchronous reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b1;
      code  = {4{mv[i].code}};
      @(negedge clk);
      start = 1'b0;
      col   = mv[i].col;
      #1;
      chk("map_row",  32'(row),  32'(mv[i].row));
      chk("map_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_row",  32'(row),  32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_done", 32'(done), 32'h0);
      chk("async_rst_err",  32'(err),  32'h0);
      chk("async_rst_idx",  32'(kidx), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      col   = 4'b0000;
    end

    // Directed sequences.
    run_seq(16'h5681, 0, -1);   // keys 1,8,6,5 with rotating scan
    run_seq(16'h0000, 0, -1);   // four presses of 0
    run_seq(16'hABCD, 1, -1);   // no column driven: timeout
    run_seq(16'h3C7E, 0, 3);    // ignored restart mid-sequence

    // Randomized sequences.
    for (int i = 0; i < 24; i++) begin
      run_seq(16'($urandom), (i % 4 == 3) ? 3 : 2, (i % 3 == 0) ? 2 : -1);
    end

    // Longer-gap instance.
    @(negedge clk);
    start2 = 1'b1;
    code2  = {4'd15, 4'd14};
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      col2 = gv[i].col;
      #1;
      chk("gap_row",  32'(row2),  32'(gv[i].row));
      chk("gap_busy", 32'(busy2), 32'(gv[i].busy));
      chk("gap_done", 32'(done2), 32'(gv[i].done));
      chk("gap_err",  32'(err2),  32'h0);
      if (gv[i].busy) chk("gap_idx", 32'(kidx2), 32'(gv[i].idx));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Behavioural and synthesizable model of the 4x4 matrix keypad itself, i.e. the switch side of the row/column scan interface.
- Takes a packed sequence of key codes and "presses" each key in turn. While a key is pressed, its row line is asserted whenever the scanner drives that key's column.
- Used as the stimulus source for the keypad scanner/passcode block in block-level and system-level benches, and as an FPGA self-test injector.

Parameters:
- NUM_KEYS, 4, number of keys in one sequence.
- HOLD_CYCLES, 2, number of column-matched clock cycles a key stays pressed.
- GAP_CYCLES, 1, number of released cycles after each key before the next press.
- TIMEOUT_CYCLES, 64, maximum cycles in PRESS before the sequence aborts with an error.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- code  in  4*NUM_KEYS  packed key codes; nibble 0 (LSBs) is pressed first.
- col  in  4  column drive from the scanner; bit3 = leftmost column.
- row  out  4  row sense to the scanner; bit3 = top row.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse when the full sequence completes without error.
- err  out  1  sticky timeout flag; cleared when the next start is accepted.
- key_idx  out  $clog2(NUM_KEYS) (minimum 1)  index of the key currently pressed or in its gap.

Behaviour:
- Reset (rst=0, async): state=IDLE, all counters 0, row=0000, busy=0, done=0, err=0, key_idx=0. Row drops to 0 immediately, including mid-press.
- Key code map (code -> row, col):
  - 1/2/3/A (codes 1,2,3,10): row 1000, cols 1000/0100/0010/0001.
  - 4/5/6/B (codes 4,5,6,11): row 0100, cols 1000/0100/0010/0001.
  - 7/8/9/C (codes 7,8,9,12): row 0010, cols 1000/0100/0010/0001.
  - * (14), 0 (0), # (15), D (13): row 0001, cols 1000/0100/0010/0001.
- match = |(col & key_col). This is true if the key's column bit is driven, even when col is not one-hot.
- row is combinational from registered state and col: row = key_row when state=PRESS and match=1, else 0000. Zero latency from col, as a physical switch would behave.
- States:
  - IDLE: on start=1, latch code into an internal register, key_idx=0, clear err, go to PRESS. busy=1 from the next cycle. start while not in IDLE is ignored, and the latched code is unchanged.
  - PRESS: each cycle, press_cnt increments; if match=1, hold_cnt increments.
    - Matched cycles accumulate across scan rotations and need not be consecutive.
    - On the edge where match=1 and hold_cnt = HOLD_CYCLES-1: clear counters, go to GAP.
    - Otherwise, on the edge where press_cnt = TIMEOUT_CYCLES-1: set err=1, go to IDLE, no done pulse.
    - If both conditions hit on the same edge, completion wins.
  - GAP: row=0000 for exactly GAP_CYCLES cycles (GAP_CYCLES=0 means a single transit cycle). Then:
    - if key_idx < NUM_KEYS-1: key_idx increments and the state returns to PRESS;
    - else: go to IDLE with done=1 for one cycle. busy falls in that same cycle.
- Counters are sized to hold TIMEOUT_CYCLES and HOLD_CYCLES without wrap. No wrap-around occurs on key_idx, because the sequence ends at NUM_KEYS-1.
- Invalid codes cannot occur: all 16 codes are mapped.

Test Plan:
- Code {5,6,8,1} (nibble 0 = 1), with a scanner model that rotates col 1000->0100->0010->0001 one step per cycle:
  - row shows 1000 only when col=1000, then 0010 at col=0100, then 0100 at col=0010, then 0100 at col=0100;
  - each key is released after 2 matched cycles;
  - done pulses once, err=0.
- Code {0,0,0,0}: row=0001 only when col=0100; four presses, then done.
- col held at 0000 after start:
  - row stays 0000;
  - err=1 after 64 cycles in PRESS, busy falls, done stays 0.
  - Next start clears err.
- start pulsed again mid-sequence with a different code: ignored; the original key order completes unchanged.
- Assert rst=0 while a key is pressed and its column is driven: row goes to 0000 asynchronously, and all outputs take their reset values. After reset, a new start runs normally.
- Codes 14 (*) and 15 (#): row 0001 at col 1000 and col 0010 respectively. With GAP_CYCLES=3, row=0000 for exactly 3 cycles between the two presses.
